// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared definitions for the instruction sequencer:
//   - state_t    : sequencer FSM state encoding
//   - instr_t    : 16-bit instruction word layout (opcode / rd / imm8)
//   - OP_*       : opcode constants used when building program images
//   - make_instr : packs the three instruction fields into one word
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [7:0] imm;
  } instr_t;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [3:0] opcode,
                                                    input logic [3:0] rd,
                                                    input logic [7:0] imm);
    instr_t w;
    w.opcode = opcode;
    w.rd     = rd;
    w.imm    = imm;
    return w;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts consecutive cycles while enable is high; expired goes high during the
// TIMEOUT-th enabled cycle so the owner can act on that same clock edge.
// Ports:
//   Clock   : system clock (rising edge)
//   Resetn  : synchronous active-low reset
//   clear   : zero the counter (has priority over enable)
//   enable  : count this cycle
//   expired : TIMEOUT enabled cycles have elapsed, including the current one
// -----------------------------------------------------------------------------
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      // Saturate at the last value so a stalled owner never sees a wrap.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Walks a program held in a synchronous ROM and hands each word to a processor,
// one at a time, waiting for the processor's Done before fetching the next.
// Ports:
//   Clock, Resetn : system clock, synchronous active-low reset
//   Start, Len    : request a run of Len instructions (accepted in IDLE/ERROR)
//   Abort         : return to IDLE immediately, keeping DIN and InstrCount
//   ADDR, ROM_Q   : ROM address (registered) and ROM data one cycle later
//   DIN, Run      : instruction word and its one-cycle issue strobe
//   Done          : processor completion pulse (only honoured in WAIT_DONE)
//   Busy          : sequence in progress
//   Finished      : one-cycle pulse after the last Done (or a Len=0 request)
//   Error         : watchdog fired while waiting for Done
//   InstrCount    : instructions completed in the current or last run
// -----------------------------------------------------------------------------
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Start,
  input  logic                Abort,
  input  logic [ADDR_W:0]     Len,
  output logic [ADDR_W-1:0]   ADDR,
  input  logic [INSTR_W-1:0]  ROM_Q,
  output logic [INSTR_W-1:0]  DIN,
  output logic                Run,
  input  logic                Done,
  output logic                Busy,
  output logic                Finished,
  output logic                Error,
  output logic [ADDR_W:0]     InstrCount
);

  // Longest program the ROM can hold; larger requests are clamped so the
  // address never wraps back over already-issued words.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t               state_reg, state_next;
  logic [ADDR_W:0]      pc_reg, pc_next;        // one spare bit: PC may reach Len
  logic [ADDR_W:0]      len_reg, len_next;
  logic [ADDR_W:0]      count_reg, count_next;
  logic [INSTR_W-1:0]   din_reg, din_next;
  logic                 finished_reg, finished_next;
  logic                 wd_expired;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (state_reg != WAIT_DONE),
    .enable  (state_reg == WAIT_DONE),
    .expired (wd_expired)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      din_reg      <= '0;
      finished_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      len_reg      <= len_next;
      count_reg    <= count_next;
      din_reg      <= din_next;
      finished_reg <= finished_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    len_next      = len_reg;
    count_next    = count_reg;
    din_next      = din_reg;
    finished_next = 1'b0;

    if (Abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, ERROR: begin
          if (Start) begin
            if (Len == '0) begin
              // Empty program: report completion without touching the ROM.
              finished_next = 1'b1;
              state_next    = IDLE;
            end else begin
              len_next   = (Len > MAX_LEN) ? MAX_LEN : Len;
              pc_next    = '0;
              count_next = '0;
              state_next = FETCH;
            end
          end
        end
        FETCH: state_next = LATCH;       // ADDR=PC presented this cycle
        LATCH: begin
          din_next   = ROM_Q;            // ROM answered the FETCH address
          state_next = ISSUE;
        end
        ISSUE: state_next = WAIT_DONE;
        WAIT_DONE: begin
          // A Done in the last watchdog cycle still wins over the timeout.
          if (Done) begin
            count_next = count_reg + 1'b1;
            pc_next    = pc_reg + 1'b1;
            if ((count_reg + 1'b1) == len_reg) begin
              finished_next = 1'b1;
              state_next    = IDLE;
            end else begin
              state_next = FETCH;
            end
          end else if (wd_expired) begin
            state_next = ERROR;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ADDR       = pc_reg[ADDR_W-1:0];
  assign DIN        = din_reg;
  assign Run        = (state_reg == ISSUE);
  assign Busy       = (state_reg != IDLE) && (state_reg != ERROR);
  assign Finished   = finished_reg;
  assign Error      = (state_reg == ERROR);
  assign InstrCount = count_reg;

endmodule
